// File: rtl/dr_scan_pkg.sv
// Shared types and dual-rail helpers for the dual-rail scan-chain sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dr_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SH_DATA    = 3'd1,
        ST_SH_SPACER  = 3'd2,
        ST_CAP_DATA   = 3'd3,
        ST_CAP_SPACER = 3'd4
    } state_t;

    // Rail pairs are {rail_1, rail_0}
    localparam logic [1:0] DR_ONE    = 2'b10;
    localparam logic [1:0] DR_ZERO   = 2'b01;
    localparam logic [1:0] DR_SPACER = 2'b00;

    // Map a single-rail bit onto its dual-rail codeword
    function automatic logic [1:0] dr_encode(input logic b);
        return b ? DR_ONE : DR_ZERO;
    endfunction

endpackage

// File: rtl/dr_cw_check.sv
// Classifies a dual-rail pair as valid codeword, spacer or illegal (both rails high).
// Latency: purely combinational.
// Backpressure: none.
module dr_cw_check
    import dr_scan_pkg::*;
(
    input  logic [1:0] i_rails,
    output logic       o_valid,
    output logic       o_spacer,
    output logic       o_illegal
);

    assign o_valid   = i_rails[1] ^ i_rails[0];
    assign o_spacer  = (i_rails == DR_SPACER);
    assign o_illegal = &i_rails;

endmodule

// File: rtl/dr_scan_ctrl.sv
// Scan sequencer for a dual-rail scan chain: data phase + spacer phase per bit, optional capture.
// Latency: start -> busy next cycle; 2 cycles per bit minimum, +2 cycles for capture.
// Backpressure: a bit moves only when si_valid and so_ready are both high; otherwise SH_DATA holds with SD spacer.
// Optional: DR_SCAN_ERRCHK_EN enables the sticky chain-tail codeword checker driving err.
module dr_scan_ctrl
    import dr_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 128,
    parameter int CNT_W     = 16
) (
    input  logic C,
    input  logic R,
    input  logic start,
    input  logic capture,
    input  logic si_valid,
    input  logic si_data,
    output logic si_ready,
    output logic so_valid,
    output logic so_data,
    input  logic so_ready,
    output logic SE_1,
    output logic SE_0,
    output logic SD_1,
    output logic SD_0,
    output logic SP,
    input  logic SO_1,
    input  logic SO_0,
    output logic busy,
    output logic err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cap;
    logic [1:0]       r_se;
    logic             r_sp;

    state_t           w_next_state;
    logic [1:0]       w_se_nxt;
    logic             w_sp_nxt;
    logic             w_complete;
    logic             w_last;

    // A shift bit completes only with both sides of the handshake present
    assign w_complete = (r_state == ST_SH_DATA) && si_valid && so_ready;
    assign w_last     = (r_cnt == LAST_IDX);

    // Next state plus the SE/SP rail values that the next state will present
    always_comb begin
        w_next_state = r_state;
        w_se_nxt     = DR_SPACER;
        w_sp_nxt     = 1'b1;
        case (r_state)
            ST_IDLE:       if (start) w_next_state = ST_SH_DATA;
            ST_SH_DATA:    if (w_complete) w_next_state = ST_SH_SPACER;
            ST_SH_SPACER: begin
                if (w_last) w_next_state = r_cap ? ST_CAP_DATA : ST_IDLE;
                else        w_next_state = ST_SH_DATA;
            end
            ST_CAP_DATA:   w_next_state = ST_CAP_SPACER;
            ST_CAP_SPACER: w_next_state = ST_IDLE;
            default:       w_next_state = ST_IDLE;
        endcase
        case (w_next_state)
            ST_SH_DATA: begin
                w_se_nxt = DR_ONE;
                w_sp_nxt = 1'b0;
            end
            ST_CAP_DATA: begin
                w_se_nxt = DR_ZERO;
                w_sp_nxt = 1'b0;
            end
            default: begin
                w_se_nxt = DR_SPACER;
                w_sp_nxt = 1'b1;
            end
        endcase
    end

    // State, bit counter, latched capture request and registered SE/SP rails
    always_ff @(posedge C) begin
        if (R) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cap   <= 1'b0;
            r_se    <= DR_SPACER;
            r_sp    <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_se    <= w_se_nxt;
            r_sp    <= w_sp_nxt;
            if (r_state == ST_IDLE && start) begin
                r_cnt <= '0;
                r_cap <= capture;
            end else if (r_state == ST_SH_SPACER) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // SD only leaves spacer in a completing cycle, so stalled cycles never shift the chain.
    // SO feeds only the handshake data path, never SE/SD/SP.
    assign {SE_1, SE_0} = r_se;
    assign SP           = r_sp;
    assign {SD_1, SD_0} = w_complete ? dr_encode(si_data) : DR_SPACER;
    assign si_ready     = w_complete;
    assign so_valid     = w_complete;
    assign so_data      = w_complete & SO_1;
    assign busy         = (r_state != ST_IDLE);

`ifdef DR_SCAN_ERRCHK_EN
    logic w_so_valid_cw;
    logic w_so_spacer;
    logic w_so_illegal;
    logic w_err_evt;
    logic r_err;

    dr_cw_check u_so_chk (
        .i_rails   ({SO_1, SO_0}),
        .o_valid   (w_so_valid_cw),
        .o_spacer  (w_so_spacer),
        .o_illegal (w_so_illegal)
    );

    assign w_err_evt = w_so_illegal
                     | (w_complete & w_so_spacer)
                     | ((r_state == ST_SH_SPACER) & (w_so_valid_cw | w_so_illegal));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge C) begin
        if (R)              r_err <= 1'b0;
        else if (w_err_evt) r_err <= 1'b1;
    end

    assign err = r_err;
`else
    // Without the checker only the true rail of the tail is needed
    logic w_unused_so0;
    assign w_unused_so0 = SO_0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_dr_scan_ctrl.sv
// Randomised bench for dr_scan_ctrl with a behavioural dual-rail chain and scoreboarded scan-out.
// Latency: n/a.
// Backpressure: randomised si_valid / so_ready stalls.
module tb_dr_scan_ctrl;

    localparam int N = 4;
    localparam logic [N-1:0] INIT = 4'b1101;

    logic C = 1'b0;
    logic R = 1'b1;
    logic start = 1'b0, capture = 1'b0;
    logic si_valid = 1'b0, si_data = 1'b0, so_ready = 1'b0;
    logic si_ready, so_valid, so_data;
    logic SE_1, SE_0, SD_1, SD_0, SP, SO_1, SO_0, busy, err;

    int checks = 0;
    int failures = 0;

    bit exp_q[$];
    bit ref_chain[$];   // front = chain tail, back = chain head

    logic mon_en = 1'b0;
    logic err_test = 1'b0;
    logic force_11 = 1'b0;
    int cyc_busy = 0, cyc_stall = 0, cyc_cap = 0, n_xfer = 0;

    always #5 C = ~C;

    dr_scan_ctrl #(.CHAIN_LEN(N), .CNT_W(16)) dut (
        .C(C), .R(R), .start(start), .capture(capture),
        .si_valid(si_valid), .si_data(si_data), .si_ready(si_ready),
        .so_valid(so_valid), .so_data(so_data), .so_ready(so_ready),
        .SE_1(SE_1), .SE_0(SE_0), .SD_1(SD_1), .SD_0(SD_0), .SP(SP),
        .SO_1(SO_1), .SO_0(SO_0), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural chain: ch[0] is the head, ch[N-1] the tail
    logic [N-1:0] ch = INIT;
    logic [N-1:0] func_d = '0;
    logic [1:0] lat_se = 2'b00, lat_sd = 2'b00;
    logic lat_sp = 1'b1;

    always @(negedge C) begin
        lat_se <= {SE_1, SE_0};
        lat_sd <= {SD_1, SD_0};
        lat_sp <= SP;
    end

    always @(posedge C) begin
        if (lat_sp === 1'b0 && lat_se == 2'b10 && lat_sd != 2'b00)
            ch <= {ch[N-2:0], (lat_sd == 2'b10)};
        else if (lat_sp === 1'b0 && lat_se == 2'b01)
            ch <= func_d;
    end

    always_comb begin
        if (force_11)          {SO_1, SO_0} = 2'b11;
        else if (SP !== 1'b0)  {SO_1, SO_0} = 2'b00;
        else                   {SO_1, SO_0} = ch[N-1] ? 2'b10 : 2'b01;
    end

    // Monitor: protocol invariants every cycle, scoreboard pop on each scan-out transfer
    always @(negedge C) begin
        logic comp;
        logic [1:0] exp_sd;
        if (mon_en) begin
            comp = si_valid && so_ready && (SE_1 === 1'b1) && (SE_0 === 1'b0) && (SP === 1'b0);
            exp_sd = comp ? (si_data ? 2'b10 : 2'b01) : 2'b00;
            chk("handshake_sd", {28'd0, si_ready, so_valid, SD_1, SD_0}, {28'd0, comp, comp, exp_sd});
            if (SP === 1'b1) chk("spacer_rails", {SE_1, SE_0, SD_1, SD_0}, 4'b0000);
            if (busy === 1'b0) chk("idle_rails", {SP, SE_1, SE_0}, 3'b100);
            if (!err_test) chk("err_quiet", err, 0);
            if (so_valid === 1'b1 && so_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL so_data_unexpected: got %0b expected no transfer", so_data);
                end else begin
                    chk("so_data", so_data, exp_q.pop_front());
                end
            end
            if (busy === 1'b1) cyc_busy++;
            if (SE_1 === 1'b1 && SE_0 === 1'b0 && SP === 1'b0 && !comp) cyc_stall++;
            if (SE_1 === 1'b0 && SE_0 === 1'b1 && SP === 1'b0) cyc_cap++;
            if (comp) n_xfer++;
        end
    end

    task automatic check_idle_vals(input string name);
        chk(name, {busy, SE_1, SE_0, SD_1, SD_0, SP, si_ready, so_valid, so_data, err},
            10'b0_00_00_1_000_0);
    endtask

    // One scan operation; abort_k>0 resets after that many bits (mode 0: in spacer, 1: in stalled data)
    task automatic run_op(input bit cap, input int vpct, input int rpct,
                          input int abort_k, input int abort_mode);
        logic [N-1:0] bits;
        int idx, guard, g, b0, s0, c0, x0;
        bit aborted;
        bits = N'($urandom);
        if (cap) func_d = N'($urandom);
        foreach (ref_chain[i]) exp_q.push_back(ref_chain[i]);
        b0 = cyc_busy; s0 = cyc_stall; c0 = cyc_cap; x0 = n_xfer;
        @(posedge C); #1;
        start = 1'b1; capture = cap;
        @(negedge C);
        chk("busy_before_start", busy, 0);
        @(posedge C); #1;
        start = 1'b0; capture = 1'($urandom);
        idx = 0; guard = 0; aborted = 0;
        while (idx < N && guard < 500) begin
            si_valid = ($urandom_range(99) >= vpct);
            so_ready = ($urandom_range(99) >= rpct);
            si_data  = bits[idx];
            start    = ($urandom_range(3) == 0);
            capture  = 1'b1;
            @(negedge C);
            guard++;
            if (guard == 1) chk("busy_rise", busy, 1);
            if (si_valid && si_ready) begin
                void'(ref_chain.pop_front());
                ref_chain.push_back(bits[idx]);
                idx++;
                if (abort_k > 0 && idx == abort_k) begin
                    aborted = 1;
                    break;
                end
            end
            @(posedge C); #1;
        end
        if (guard >= 500) chk("shift_timeout", idx, N);
        if (aborted) begin
            @(posedge C); #1;
            start = 1'b0; si_valid = 1'b0;
            if (abort_mode == 1) begin
                @(posedge C); #1;
            end
            R = 1'b1;
            @(posedge C); #1;
            R = 1'b0;
            @(negedge C);
            check_idle_vals("abort_reset_vals");
            chk("abort_leftover", exp_q.size(), N - abort_k);
            exp_q.delete();
        end else begin
            @(posedge C); #1;
            start = 1'b0; si_valid = 1'b0;
            so_ready = 1'($urandom);
            g = 0;
            do begin
                @(negedge C);
                g++;
            end while (busy === 1'b1 && g < 20);
            chk("end_idle", busy, 0);
            chk("busy_cycles", cyc_busy - b0, 2 * N + (cyc_stall - s0) + (cap ? 2 : 0));
            chk("xfers", n_xfer - x0, N);
            chk("cap_cycles", cyc_cap - c0, cap);
            if (vpct == 0 && rpct == 0) chk("no_stalls", cyc_stall - s0, 0);
            chk("exp_q_drained", exp_q.size(), 0);
            if (cap) begin
                ref_chain.delete();
                for (int i = N - 1; i >= 0; i--) ref_chain.push_back(func_d[i]);
            end
        end
        so_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = N - 1; i >= 0; i--) ref_chain.push_back(INIT[i]);
        R = 1'b1;
        repeat (2) @(posedge C);
        @(negedge C);
        check_idle_vals("reset_vals");
        @(posedge C); #1;
        R = 1'b0;
        mon_en = 1'b1;

        run_op(0, 0, 0, 0, 0);
        run_op(0, 40, 0, 0, 0);
        run_op(0, 0, 40, 0, 0);
        run_op(1, 0, 0, 0, 0);
        run_op(0, 30, 30, 0, 0);
        run_op(0, 0, 0, 2, 0);
        run_op(0, 0, 0, 0, 0);
        run_op(0, 20, 20, 3, 1);
        run_op(1, 25, 25, 0, 0);
        for (int k = 0; k < 8; k++)
            run_op(1'($urandom_range(1)), $urandom_range(50), $urandom_range(50), 0, 0);
        run_op(0, 0, 0, 0, 0);

        // Illegal tail codeword for one idle cycle
        @(posedge C); #1;
        err_test = 1'b1;
        force_11 = 1'b1;
        @(negedge C);
        chk("err_before_edge", err, 0);
        @(posedge C); #1;
        force_11 = 1'b0;
        @(negedge C);
`ifdef DR_SCAN_ERRCHK_EN
        chk("err_rise", err, 1);
        repeat (3) @(negedge C);
        chk("err_sticky", err, 1);
`else
        chk("err_tied", err, 0);
        repeat (3) @(negedge C);
        chk("err_tied_later", err, 0);
`endif
        @(posedge C); #1;
        R = 1'b1;
        @(posedge C); #1;
        R = 1'b0;
        @(negedge C);
        chk("err_clear", err, 0);
        err_test = 1'b0;
        repeat (2) @(negedge C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
